// File: rtl/rw_bank_scheduler.sv
// Per-bank read/write scheduler: pops the read or write request FIFO into a
// one-entry command slot, batches writes, inserts turnaround gaps, tracks the open row.
module rw_bank_scheduler #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RA_POS     = 20,
   parameter int unsigned RA_BITS    = 10,
   parameter int unsigned WR_BURST   = 4,
   parameter int unsigned TURNAROUND = 2,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   input  logic                  rd_valid_i,
   input  logic                  rd_mid_i,
   output logic                  rd_grant_o,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  wr_valid_i,
   input  logic                  wr_mid_i,
   output logic                  wr_grant_o,
   output logic [DATA_WIDTH-1:0] cmd_data_o,
   output logic                  cmd_valid_o,
   output logic                  cmd_write_o,
   output logic                  cmd_row_hit_o,
   input  logic                  cmd_ready_i,
   output logic [RA_BITS-1:0]    open_row_o,
   output logic                  row_open_o,
   output logic [1:0]            mode_o
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam int unsigned WW = $clog2(WR_BURST + 1);
   localparam int unsigned TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
   localparam logic [SW-1:0] STREAK_LIM = SW'(STARVE_MAX);
   localparam logic [WW-1:0] BURST_LIM  = WW'(WR_BURST);
   localparam logic [TW-1:0] TURN_INIT  = TW'(TURNAROUND - 1);

   typedef enum logic [1:0] {
      READ  = 2'd0,
      WRITE = 2'd1,
      TURN  = 2'd2
   } mode_t;

   mode_t           state, state_nxt;
   mode_t           target, target_nxt;
   logic [TW-1:0]   turn_cnt, turn_nxt;
   logic [SW-1:0]   rd_streak, rd_streak_nxt;
   logic [WW-1:0]   wr_cnt, wr_cnt_nxt;
   logic            free, to_write, to_read;
   logic            rd_grant, wr_grant, load;
   logic [DATA_WIDTH-1:0] load_data;
   logic [RA_BITS-1:0]    load_row;

   // Read FIFO fill level is status only; it has no role in the policy.
   logic rd_mid_unused;
   assign rd_mid_unused = rd_mid_i;

   assign free     = !cmd_valid_o || cmd_ready_i;
   assign to_write = wr_valid_i && (wr_mid_i || !rd_valid_i || rd_streak == STREAK_LIM);
   // Counter saturates at the burst length, so equality stands in for >=.
   assign to_read  = rd_valid_i && (!wr_valid_i || (wr_cnt == BURST_LIM && !wr_mid_i));

   always_comb begin
      state_nxt     = state;
      target_nxt    = target;
      turn_nxt      = turn_cnt;
      rd_streak_nxt = rd_streak;
      wr_cnt_nxt    = wr_cnt;
      rd_grant      = 1'b0;
      wr_grant      = 1'b0;
      unique case (state)
         READ: begin
            if (to_write) begin
               state_nxt  = TURN;
               target_nxt = WRITE;
               turn_nxt   = TURN_INIT;
            end else if (free && rd_valid_i) begin
               rd_grant = 1'b1;
               if (rd_streak != STREAK_LIM) rd_streak_nxt = rd_streak + SW'(1);
            end
         end
         WRITE: begin
            if (to_read) begin
               state_nxt  = TURN;
               target_nxt = READ;
               turn_nxt   = TURN_INIT;
            end else if (free && wr_valid_i) begin
               wr_grant = 1'b1;
               if (wr_cnt != BURST_LIM) wr_cnt_nxt = wr_cnt + WW'(1);
            end
         end
         TURN: begin
            if (turn_cnt == '0) begin
               state_nxt = target;
               if (target == READ) rd_streak_nxt = '0;
               else                wr_cnt_nxt    = '0;
            end else begin
               turn_nxt = turn_cnt - TW'(1);
            end
         end
         default: state_nxt = READ;
      endcase
      if (rst) begin
         rd_grant = 1'b0;
         wr_grant = 1'b0;
      end
   end

   assign rd_grant_o = rd_grant;
   assign wr_grant_o = wr_grant;
   assign load       = rd_grant || wr_grant;
   assign load_data  = rd_grant ? rd_data_i : wr_data_i;
   assign load_row   = load_data[RA_POS +: RA_BITS];
   assign mode_o     = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= READ;
         target        <= READ;
         turn_cnt      <= '0;
         rd_streak     <= '0;
         wr_cnt        <= '0;
         cmd_data_o    <= '0;
         cmd_valid_o   <= 1'b0;
         cmd_write_o   <= 1'b0;
         cmd_row_hit_o <= 1'b0;
         open_row_o    <= '0;
         row_open_o    <= 1'b0;
      end else begin
         state     <= state_nxt;
         target    <= target_nxt;
         turn_cnt  <= turn_nxt;
         rd_streak <= rd_streak_nxt;
         wr_cnt    <= wr_cnt_nxt;
         if (load) begin
            cmd_data_o    <= load_data;
            cmd_valid_o   <= 1'b1;
            cmd_write_o   <= wr_grant;
            cmd_row_hit_o <= row_open_o && (load_row == open_row_o);
            open_row_o    <= load_row;
            row_open_o    <= 1'b1;
         end else if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
         end
      end
   end

endmodule
